lsu_ctrl: RTL and testbench

//  Load/store initiator between the core's execute stage and the byte-masked, word-addressed data memory.
//  - Memory contract: combinational read; masked write on posedge clk when mem_en=1.
//  - Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW byte-address requests into word address + byte mask.
//  - Shifts store data into byte lanes; extracts and sign/zero-extends load data.
//  - With the optional feature compiled in, splits word-crossing accesses into two memory cycles.

---
 rtl/lsu_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store initiator for a byte-masked, word-addressed, combinational-read memory.
// Define LSU_MISALIGN_SPLIT_EN to execute word-crossing accesses as two memory cycles.
module lsu_ctrl #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_rdata
);
    localparam int unsigned BA_W = ADDR_W + 2;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [BA_W-1:0]   addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf0_q, buf0_d;
    logic              rdy_q, rdy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_mask_q, mem_mask_d;

    logic              src_we;
    logic [2:0]        src_f3;
    logic [BA_W-1:0]   src_addr;
    logic [31:0]       src_wdata;
    logic [1:0]        off_c;
    logic [2:0]        size_c;
    logic [3:0]        smask_c;
    logic              legal_c, misalign_c, bad_c, split_c;
    logic [ADDR_W-1:0] word0_c;
    logic [63:0]       lane64_c;
    logic [7:0]        bm8_c;
    logic [5:0]        sh_c;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:BA_W];

    // Decode the live request while IDLE (for the ACC0 setup), the captured copy afterwards
    assign src_we    = (state_q == IDLE) ? req_we               : we_q;
    assign src_f3    = (state_q == IDLE) ? req_funct3           : f3_q;
    assign src_addr  = (state_q == IDLE) ? req_addr[BA_W-1:0]   : addr_q;
    assign src_wdata = (state_q == IDLE) ? req_wdata            : wdata_q;

    assign off_c    = src_addr[1:0];
    assign word0_c  = src_addr[BA_W-1:2];
    assign sh_c     = {1'b0, off_c, 3'b000};
    assign lane64_c = {32'b0, src_wdata} << sh_c;
    assign bm8_c    = {4'b0, smask_c} << off_c;

    always_comb begin
        size_c  = 3'd4;
        smask_c = 4'b1111;
        case (src_f3[1:0])
            2'b00:   begin size_c = 3'd1; smask_c = 4'b0001; end
            2'b01:   begin size_c = 3'd2; smask_c = 4'b0011; end
            default: begin size_c = 3'd4; smask_c = 4'b1111; end
        endcase
    end

    always_comb begin
        legal_c = 1'b0;
        case (src_f3)
            3'b000, 3'b001, 3'b010: legal_c = 1'b1;
            3'b100, 3'b101:         legal_c = !src_we;
            default:                legal_c = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    assign misalign_c = 1'b0;
    assign split_c    = !bad_c && (({1'b0, off_c} + size_c) > 3'd4);
`else
    assign misalign_c = ((src_f3[1:0] == 2'b01) && off_c[0]) ||
                        ((src_f3[1:0] == 2'b10) && (off_c != 2'b00));
    assign split_c    = 1'b0;
`endif
    assign bad_c = !legal_c || misalign_c;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
            3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
            3'b100:  extend = {24'b0, raw[7:0]};
            3'b101:  extend = {16'b0, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf0_d      = buf0_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'b0;
        rsp_err_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 32'b0;
        mem_mask_d  = 4'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[BA_W-1:0];
                    wdata_d = req_wdata;
                    state_d = ACC0;
                    if (!bad_c) begin
                        mem_en_d    = req_we;
                        mem_addr_d  = word0_c;
                        mem_wdata_d = lane64_c[31:0];
                        mem_mask_d  = bm8_c[3:0];
                    end
                end
            end
            ACC0: begin
                buf0_d = mem_rdata;
                if (split_c) begin
                    state_d     = ACC1;
                    mem_en_d    = we_q;
                    mem_addr_d  = word0_c + ADDR_W'(1);
                    mem_wdata_d = lane64_c[63:32];
                    mem_mask_d  = bm8_c[7:4];
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bad_c;
                    if (!bad_c && !we_q)
                        rsp_rdata_d = extend(f3_q, 32'(mem_rdata >> sh_c));
                end
            end
            ACC1: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                if (!we_q)
                    rsp_rdata_d = extend(f3_q, 32'({mem_rdata, buf0_q} >> sh_c));
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b0;
            addr_q      <= '0;
            wdata_q     <= 32'b0;
            buf0_q      <= 32'b0;
            rdy_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'b0;
            mem_mask_q  <= 4'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf0_q      <= buf0_d;
            rdy_q       <= rdy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mask_q  <= mem_mask_d;
        end
    end

    assign req_ready = rdy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_mask  = mem_mask_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed table, corner sequences and random traffic against a byte-array model.
`timescale 1ns/1ps
module tb_lsu_ctrl;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned NWORDS = 256;
    localparam int unsigned NBYTES = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [3:0]        mem_mask;

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory with a backdoor write port used for preloading
    logic [31:0]       mem [NWORDS];
    logic              bd_en;
    logic [ADDR_W-1:0] bd_addr;
    logic [31:0]       bd_data;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (mem_en)
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    logic [7:0] ref_b [NBYTES];
    int n_vec = 0;
    int n_mis = 0;

    logic              a0_en, a1_en;
    logic [ADDR_W-1:0] a0_addr, a1_addr;
    logic [3:0]        a0_mask, a1_mask;
    logic [31:0]       a0_wdata, a1_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic bd_write(input int w, input logic [31:0] d);
        @(negedge clk);
        bd_en = 1'b1; bd_addr = ADDR_W'(w); bd_data = d;
        @(posedge clk); #1;
        bd_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_b[4*w + i] = d[8*i +: 8];
    endtask

    // Reference: byte-granular memory view with the RV32I size/sign rules
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic er,
                                  output int lat, output int ens);
        int ba, sz, off;
        logic legal;
        logic [31:0] raw;
        ba  = int'(a[9:0]);
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = ba % 4;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        er  = !legal;
`ifndef LSU_MISALIGN_SPLIT_EN
        if (ba % sz != 0) er = 1'b1;
`endif
        lat = 2; ens = 0; rd = 32'b0;
        if (!er) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (off + sz > 4) lat = 3;
`endif
            if (we) begin
                for (int i = 0; i < sz; i++) ref_b[(ba + i) % NBYTES] = wd[8*i +: 8];
                ens = lat - 1;
            end else begin
                raw = 32'b0;
                for (int i = 0; i < sz; i++) raw[8*i +: 8] = ref_b[(ba + i) % NBYTES];
                case (f3)
                    3'd0:    rd = {{24{raw[7]}}, raw[7:0]};
                    3'd1:    rd = {{16{raw[15]}}, raw[15:0]};
                    default: rd = raw;
                endcase
            end
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int ens);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; ens = 0;
        a0_en = mem_en; a0_addr = mem_addr; a0_mask = mem_mask; a0_wdata = mem_wdata;
        a1_en = 1'b0; a1_addr = '0; a1_mask = 4'b0; a1_wdata = 32'b0;
        if (mem_en) ens++;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (!rsp_valid) begin
                a1_en = mem_en; a1_addr = mem_addr; a1_mask = mem_mask; a1_wdata = mem_wdata;
            end
            if (mem_en) ens++;
        end
        rd = rsp_rdata; er = rsp_err;
        @(negedge clk);
    endtask

    task automatic run(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, elat, ens, eens;
        model(we, f3, a, wd, erd, eer, elat, eens);
        do_req(we, f3, a, wd, rd, er, lat, ens);
        check({nm, "_rdata"}, rd, erd);
        check({nm, "_err"}, 32'(er), 32'(eer));
        check({nm, "_lat"}, 32'(lat), 32'(elat));
        check({nm, "_en_cycles"}, 32'(ens), 32'(eens));
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        chk_mem;
        logic [7:0]  exp_maddr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_mwdata;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] rd, erd, w;
        logic er, eer;
        int lat, elat, ens, eens, badw;
        logic [8:0] pat, rdy;

        tbl[0]  = '{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 8'd4, 4'hF, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 8'd0, 4'h0, 32'h0};
        tbl[2]  = '{1'b1, 3'b000, 32'h13,       32'h000000A5, 32'h0,        1'b0, 1'b1, 8'd4, 4'h8, 32'hA5000000};
        tbl[3]  = '{1'b0, 3'b000, 32'h13,       32'h0,        32'hFFFFFFA5, 1'b0, 1'b0, 8'd0, 4'h0, 32'h0};
        tbl[4]  = '{1'b0, 3'b100, 32'h13,       32'h0,        32'h000000A5, 1'b0, 1'b0, 8'd0, 4'h0, 32'h0};
        tbl[5]  = '{1'b0, 3'b010, 32'hFFFFFC10, 32'h0,        32'hA5ADBEEF, 1'b0, 1'b0, 8'd0, 4'h0, 32'h0};
        tbl[6]  = '{1'b0, 3'b001, 32'h12,       32'h0,        32'hFFFFA5AD, 1'b0, 1'b0, 8'd0, 4'h0, 32'h0};
        tbl[7]  = '{1'b0, 3'b101, 32'h10,       32'h0,        32'h0000BEEF, 1'b0, 1'b0, 8'd0, 4'h0, 32'h0};
        tbl[8]  = '{1'b1, 3'b001, 32'h22,       32'hFFFF1234, 32'h0,        1'b0, 1'b1, 8'd8, 4'hC, 32'h12340000};
        tbl[9]  = '{1'b0, 3'b001, 32'h22,       32'h0,        32'h00001234, 1'b0, 1'b0, 8'd0, 4'h0, 32'h0};
        tbl[10] = '{1'b0, 3'b000, 32'h23,       32'h0,        32'h00000012, 1'b0, 1'b0, 8'd0, 4'h0, 32'h0};
        tbl[11] = '{1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1, 1'b1, 8'd0, 4'h0, 32'h0};
        tbl[12] = '{1'b1, 3'b100, 32'h10,       32'h0,        32'h0,        1'b1, 1'b1, 8'd0, 4'h0, 32'h0};
        tbl[13] = '{1'b1, 3'b111, 32'h10,       32'h0,        32'h0,        1'b1, 1'b1, 8'd0, 4'h0, 32'h0};
        tbl[14] = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hA5ADBEEF, 1'b0, 1'b0, 8'd0, 4'h0, 32'h0};
        tbl[15] = '{1'b0, 3'b110, 32'h10,       32'h0,        32'h0,        1'b1, 1'b0, 8'd0, 4'h0, 32'h0};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'b0; req_wdata = 32'b0;
        bd_en = 1'b0; bd_addr = '0; bd_data = 32'b0;

        for (int i = 0; i < int'(NWORDS); i++) bd_write(i, $urandom);

        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_mem_en", 32'(mem_en), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_mem_mask", 32'(mem_mask), 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, erd, eer, elat, eens);
            do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, lat, ens);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
            check($sformatf("tbl%0d_en_cycles", i), 32'(ens), 32'(eens));
            if (tbl[i].chk_mem) begin
                check($sformatf("tbl%0d_mem_addr", i), 32'(a0_addr), 32'(tbl[i].exp_maddr));
                check($sformatf("tbl%0d_mem_mask", i), 32'(a0_mask), 32'(tbl[i].exp_mask));
                check($sformatf("tbl%0d_mem_wdata", i), a0_wdata, tbl[i].exp_mwdata);
            end
        end

        // Reset asserted in the middle of ACC0 of a store
        bd_write(16, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midrst_en_before", 32'(mem_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_en_after", 32'(mem_en), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("midrst_rsp_valid_held", 32'(rsp_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        check("midrst_mem_word", mem[16], 32'hCAFEF00D);
        run("midrst_readback", 1'b0, 3'b010, 32'h40, 32'h0);

        // req_valid held continuously: accepts only from IDLE
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            pat[k] = rsp_valid;
            rdy[k] = req_ready;
        end
        @(negedge clk); req_valid = 1'b0;
        check("b2b_rsp_pattern", 32'(pat), 32'(9'b010010010));
        check("b2b_ready_pattern", 32'(rdy), 32'(9'b100100100));
        @(negedge clk);

`ifdef LSU_MISALIGN_SPLIT_EN
        bd_write(4, 32'h44332211);
        bd_write(5, 32'h88776655);
        run("split_lw12", 1'b0, 3'b010, 32'h12, 32'h0);
        check("split_lw12_data", rsp_rdata, 32'h66554433);
        check("split_lw12_acc0_addr", 32'(a0_addr), 32'd4);
        check("split_lw12_acc1_addr", 32'(a1_addr), 32'd5);
        run("split_sh17", 1'b1, 3'b001, 32'h17, 32'h0000BBAA);
        check("split_sh17_acc0_addr", 32'(a0_addr), 32'd5);
        check("split_sh17_acc0_mask", 32'(a0_mask), 32'h8);
        check("split_sh17_acc0_wdata", a0_wdata, 32'hAA000000);
        check("split_sh17_acc1_addr", 32'(a1_addr), 32'd6);
        check("split_sh17_acc1_mask", 32'(a1_mask), 32'h1);
        check("split_sh17_acc1_wdata", a1_wdata, 32'h000000BB);
        bd_write(255, 32'h11223344);
        bd_write(0, 32'h55667788);
        run("wrap_lw3ff", 1'b0, 3'b010, 32'h3FF, 32'h0);
        check("wrap_lw3ff_data", rsp_rdata, 32'h66778811);
        check("wrap_acc0_addr", 32'(a0_addr), 32'd255);
        check("wrap_acc1_addr", 32'(a1_addr), 32'd0);
`else
        run("nosplit_sw11", 1'b1, 3'b010, 32'h11, 32'h12345678);
        check("nosplit_sw11_err", 32'(rsp_err), 32'd1);
        check("nosplit_sw11_acc0_mask", 32'(a0_mask), 32'd0);
        run("nosplit_lh11", 1'b0, 3'b001, 32'h11, 32'h0);
        run("nosplit_lw12", 1'b0, 3'b010, 32'h12, 32'h0);
        run("nosplit_lh3ff", 1'b0, 3'b001, 32'h3FF, 32'h0);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [2:0] f3;
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                    3: f3 = 3'b100; default: f3 = 3'b101;
                endcase
            end
            a = $urandom;
            case ($urandom_range(0, 3))
                0: a[9:0] = 10'($urandom_range(0, 63));
                1: a[9:0] = 10'($urandom_range(1020, 1023));
                default: ;
            endcase
            run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), f3, a, $urandom);
        end

        badw = 0;
        for (int wi = 0; wi < int'(NWORDS); wi++) begin
            w = {ref_b[4*wi+3], ref_b[4*wi+2], ref_b[4*wi+1], ref_b[4*wi]};
            if (mem[wi] !== w) badw++;
        end
        check("final_mem_bad_words", 32'(badw), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
